// File: rtl/synrefsm1_pkg.sv
// Shared types for the two-state Moore sequencer.
// The encoding is fixed so that the state register can drive the output directly.
package synrefsm1_pkg;

  typedef enum logic {
    STATE_A = 1'b0,
    STATE_B = 1'b1
  } state_e;

  localparam state_e RESET_STATE = STATE_B;

endpackage

// File: rtl/synrefsm1_moore.sv
// Two-state Moore parity sequencer: toggles on every in=0 sample.
// out is 1 while an even number of zeros has been seen since reset.
module synrefsm1_moore
  import synrefsm1_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  state_e r_state;
  state_e w_next_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!in) begin
      case (r_state)
        STATE_A: w_next_state = STATE_B;
        STATE_B: w_next_state = STATE_A;
        default: w_next_state = RESET_STATE;
      endcase
    end
  end

  // B is encoded as 1, so the register bit is the registered, glitch-free output.
  assign out = r_state;

endmodule

// File: tb/tb_synrefsm1_moore.sv
// Directed bench for the two-state Moore parity sequencer.
module tb_synrefsm1_moore;

  logic clk;
  logic reset;
  logic in;
  logic out;

  int n_checks;
  int n_errors;

  synrefsm1_moore dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: out=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one input value, let one rising edge pass, then check out.
  task automatic step(input string tag, input logic v, input logic exp);
    in = v;
    @(posedge clk);
    #1;
    chk(tag, out, exp);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: out=%b expected run completion", out);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    in    = 1'b1;

    // Reset hold.
    #1;
    chk("reset_async_start", out, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", out, 1'b1);
    end
    reset = 1'b0;
    #1;
    chk("reset_release", out, 1'b1);
    step("post_reset_in1_a", 1'b1, 1'b1);
    step("post_reset_in1_b", 1'b1, 1'b1);

    // B->A, hold in A, A->B, then toggle again.
    step("b_to_a",    1'b0, 1'b0);
    step("a_hold_1",  1'b1, 1'b0);
    step("a_hold_2",  1'b1, 1'b0);
    step("a_to_b",    1'b0, 1'b1);
    step("b_to_a_2",  1'b0, 1'b0);

    // Fresh reset, then the toggle sequence 0,0,0,1,0 -> 0,1,0,0,1.
    reset = 1'b1;
    #1;
    chk("reset_from_a", out, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("seq_0", 1'b0, 1'b0);
    step("seq_1", 1'b0, 1'b1);
    step("seq_2", 1'b0, 1'b0);
    step("seq_3", 1'b1, 1'b0);
    step("seq_4", 1'b0, 1'b1);

    // Async reset between edges while in A.
    step("drive_to_a", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_reset_mid", out, 1'b1);
    step("reset_hold_in0_a", 1'b0, 1'b1);
    step("reset_hold_in0_b", 1'b0, 1'b1);
    reset = 1'b0;
    step("release_in1", 1'b1, 1'b1);

    // Reset coincident with a rising edge in B with in=0.
    @(negedge clk);
    in = 1'b0;
    @(posedge clk);
    reset = 1'b1;
    #1;
    chk("collision_edge", out, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("collision_release", out, 1'b1);
    step("after_collision", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
